// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: register index and the forwarding-select encoding.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    FWD_RF      = 2'b00,
    FWD_MEM     = 2'b01,
    FWD_WB      = 2'b10,
    FWD_MEM_ALT = 2'b11
  } fwd_sel_t;

endpackage

// File: rtl/hazard_forward_unit_mc_scoreboard.sv
// Multi-cycle op scoreboard: slot allocation, latency countdown and retire strobes.
module mc_scoreboard
  import cpu_types_pkg::*;
#(
  parameter int MC_DEPTH = 4,
  parameter int REG_W    = $bits(regbits_t),
  parameter int LAT_W    = 4,
  parameter int TAG_W    = 2,
  parameter int OCC_W    = 3
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            issue,
  input  logic [REG_W-1:0]                issue_dest,
  input  logic [LAT_W-1:0]                issue_lat,
  output logic [TAG_W-1:0]                tag,
  output logic [MC_DEPTH-1:0]             slot_valid,
  output logic [MC_DEPTH-1:0][REG_W-1:0]  slot_dest,
  output logic [MC_DEPTH-1:0]             retire,
  output logic [OCC_W-1:0]                occupancy
);

  logic [MC_DEPTH-1:0][LAT_W-1:0] slot_cnt;
  logic [MC_DEPTH-1:0]            alloc;
  logic                           any_free;
  logic                           dest_clash;

  // A slot that retires this cycle is still valid, so it is never picked here.
  always_comb begin
    tag      = '0;
    alloc    = '0;
    any_free = 1'b0;
    for (int s = 0; s < MC_DEPTH; s++) begin
      if (!any_free && !slot_valid[s]) begin
        any_free = 1'b1;
        tag      = TAG_W'(s);
        alloc[s] = issue;
      end
    end
  end

  always_comb begin
    retire     = '0;
    occupancy  = '0;
    dest_clash = 1'b0;
    for (int s = 0; s < MC_DEPTH; s++) begin
      retire[s] = slot_valid[s] && (slot_cnt[s] == LAT_W'(1));
      occupancy = occupancy + OCC_W'(slot_valid[s] && !retire[s]);
      if (slot_valid[s] && (slot_dest[s] == issue_dest) && (issue_dest != '0)) begin
        dest_clash = 1'b1;
      end
    end
    occupancy = occupancy + OCC_W'(issue);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      slot_valid <= '0;
      slot_dest  <= '0;
      slot_cnt   <= '0;
    end else begin
      for (int s = 0; s < MC_DEPTH; s++) begin
        if (alloc[s]) begin
          slot_valid[s] <= 1'b1;
          slot_dest[s]  <= issue_dest;
          slot_cnt[s]   <= (issue_lat == '0) ? LAT_W'(1) : issue_lat;
        end else if (retire[s]) begin
          slot_valid[s] <= 1'b0;
          slot_cnt[s]   <= '0;
        end else if (slot_valid[s]) begin
          slot_cnt[s]   <= slot_cnt[s] - LAT_W'(1);
        end
      end
    end
  end

  issue_needs_free_slot: assert property (@(posedge CLK) disable iff (RST) issue |-> any_free);
  issue_dest_not_in_flight: assert property (@(posedge CLK) disable iff (RST) issue |-> !dest_clash);

endmodule

// File: rtl/hazard_forward_unit.sv
// Operand forwarding selects, IF/ID stall generation and stall-cycle counter.
module hazard_forward_unit
  import cpu_types_pkg::*;
#(
  parameter int NUM_SRC  = 2,
  parameter int REG_W    = $bits(regbits_t),
  parameter int MC_DEPTH = 4,
  parameter int MAX_LAT  = 8,
  parameter int LAT_W    = $clog2(MAX_LAT + 1),
  parameter int TAG_W    = $clog2(MC_DEPTH)
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NUM_SRC-1:0][REG_W-1:0]  ex_src,
  input  logic [NUM_SRC-1:0][REG_W-1:0]  id_src,
  input  logic [NUM_SRC-1:0]             id_src_used,
  input  logic [REG_W-1:0]               id_dest,
  input  logic                           id_regwrite,
  input  logic                           id_mc,
  input  logic [REG_W-1:0]               ex_dest,
  input  logic                           ex_regwrite,
  input  logic                           ex_is_load,
  input  logic                           ex_mc_issue,
  input  logic [LAT_W-1:0]               ex_mc_lat,
  input  logic [REG_W-1:0]               mem_dest,
  input  logic                           mem_regwrite,
  input  logic                           mem_alt,
  input  logic [REG_W-1:0]               wb_dest,
  input  logic                           wb_regwrite,
  input  logic                           perf_clr,
  output fwd_sel_t [NUM_SRC-1:0]         fwd_sel,
  output logic                           stall,
  output logic [TAG_W-1:0]               mc_tag,
  output logic [MC_DEPTH-1:0]            mc_wb_valid,
  output logic [MC_DEPTH-1:0][REG_W-1:0] mc_wb_dest,
  output logic [31:0]                    stall_count
);

  localparam int OCC_W = $clog2(MC_DEPTH + 2);

  logic [MC_DEPTH-1:0]            slot_valid;
  logic [MC_DEPTH-1:0][REG_W-1:0] slot_dest;
  logic [OCC_W-1:0]               occupancy;
  logic                           load_use, raw_mc, waw_mc, struct_mc;
  logic [31:0]                    perf_cnt;

  mc_scoreboard #(
    .MC_DEPTH (MC_DEPTH),
    .REG_W    (REG_W),
    .LAT_W    (LAT_W),
    .TAG_W    (TAG_W),
    .OCC_W    (OCC_W)
  ) u_scoreboard (
    .CLK        (CLK),
    .RST        (RST),
    .issue      (ex_mc_issue),
    .issue_dest (ex_dest),
    .issue_lat  (ex_mc_lat),
    .tag        (mc_tag),
    .slot_valid (slot_valid),
    .slot_dest  (slot_dest),
    .retire     (mc_wb_valid),
    .occupancy  (occupancy)
  );

  assign mc_wb_dest = slot_dest;

  // The younger EX/MEM result shadows MEM/WB; r0 always reads the register file.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd_sel[i] = FWD_RF;
      if (ex_src[i] != '0) begin
        if (mem_regwrite && (mem_dest == ex_src[i])) begin
          fwd_sel[i] = mem_alt ? FWD_MEM_ALT : FWD_MEM;
        end else if (wb_regwrite && (wb_dest == ex_src[i])) begin
          fwd_sel[i] = FWD_WB;
        end
      end
    end
  end

  // Slots with dest 0 never match because only nonzero sources/dests are compared.
  always_comb begin
    load_use = 1'b0;
    raw_mc   = 1'b0;
    waw_mc   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ex_is_load && ex_regwrite && (ex_dest != '0) && id_src_used[i] && (id_src[i] == ex_dest)) begin
        load_use = 1'b1;
      end
      for (int s = 0; s < MC_DEPTH; s++) begin
        if (id_src_used[i] && (id_src[i] != '0) && slot_valid[s] && (slot_dest[s] == id_src[i])) begin
          raw_mc = 1'b1;
        end
      end
    end
    for (int s = 0; s < MC_DEPTH; s++) begin
      if (id_regwrite && (id_dest != '0) && slot_valid[s] && (slot_dest[s] == id_dest)) begin
        waw_mc = 1'b1;
      end
    end
    struct_mc = id_mc && (occupancy == OCC_W'(MC_DEPTH));
    stall     = load_use || raw_mc || waw_mc || struct_mc;
  end

  always_ff @(posedge CLK) begin
    if (RST || perf_clr) begin
      perf_cnt <= '0;
    end else if (stall && (perf_cnt != 32'hFFFF_FFFF)) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end

  assign stall_count = perf_cnt;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench: vector table, hand-written multi-cycle sequences, random vs. model.
module tb_hazard_forward_unit;
  import cpu_types_pkg::*;

  localparam int NUM_SRC  = 2;
  localparam int REG_W    = 5;
  localparam int MC_DEPTH = 4;
  localparam int LAT_W    = 4;
  localparam int TAG_W    = 2;

  logic CLK = 1'b0;
  logic RST;
  logic [NUM_SRC-1:0][REG_W-1:0]  ex_src, id_src;
  logic [NUM_SRC-1:0]             id_src_used;
  logic [REG_W-1:0]               id_dest, ex_dest, mem_dest, wb_dest;
  logic                           id_regwrite, id_mc, ex_regwrite, ex_is_load, ex_mc_issue;
  logic                           mem_regwrite, mem_alt, wb_regwrite, perf_clr;
  logic [LAT_W-1:0]               ex_mc_lat;
  fwd_sel_t [NUM_SRC-1:0]         fwd_sel;
  logic                           stall;
  logic [TAG_W-1:0]               mc_tag;
  logic [MC_DEPTH-1:0]            mc_wb_valid;
  logic [MC_DEPTH-1:0][REG_W-1:0] mc_wb_dest;
  logic [31:0]                    stall_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int ex_s0, ex_s1, mem_d, mem_w, mem_a, wb_d, wb_w;
    int ex_d, ex_w, ld, id_s0, id_s1, used;
    int f0, f1, st;
  } vec_t;

  typedef struct {
    int         slot;
    logic [4:0] dest;
    int         ret;
  } op_t;

  op_t         ops[$];
  int          cyc;
  logic [31:0] m_cnt;

  hazard_forward_unit dut (
    .CLK(CLK), .RST(RST), .ex_src(ex_src), .id_src(id_src), .id_src_used(id_src_used),
    .id_dest(id_dest), .id_regwrite(id_regwrite), .id_mc(id_mc),
    .ex_dest(ex_dest), .ex_regwrite(ex_regwrite), .ex_is_load(ex_is_load),
    .ex_mc_issue(ex_mc_issue), .ex_mc_lat(ex_mc_lat),
    .mem_dest(mem_dest), .mem_regwrite(mem_regwrite), .mem_alt(mem_alt),
    .wb_dest(wb_dest), .wb_regwrite(wb_regwrite), .perf_clr(perf_clr),
    .fwd_sel(fwd_sel), .stall(stall), .mc_tag(mc_tag), .mc_wb_valid(mc_wb_valid),
    .mc_wb_dest(mc_wb_dest), .stall_count(stall_count)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clearInputs();
    ex_src = '0; id_src = '0; id_src_used = '0;
    id_dest = '0; id_regwrite = 1'b0; id_mc = 1'b0;
    ex_dest = '0; ex_regwrite = 1'b0; ex_is_load = 1'b0;
    ex_mc_issue = 1'b0; ex_mc_lat = '0;
    mem_dest = '0; mem_regwrite = 1'b0; mem_alt = 1'b0;
    wb_dest = '0; wb_regwrite = 1'b0; perf_clr = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    clearInputs();
    RST = 1'b1;
    nextCycle();
    RST = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    clearInputs();
    ex_src[0] = 5'(v.ex_s0);  ex_src[1] = 5'(v.ex_s1);
    mem_dest = 5'(v.mem_d);   mem_regwrite = 1'(v.mem_w); mem_alt = 1'(v.mem_a);
    wb_dest = 5'(v.wb_d);     wb_regwrite = 1'(v.wb_w);
    ex_dest = 5'(v.ex_d);     ex_regwrite = 1'(v.ex_w);   ex_is_load = 1'(v.ld);
    id_src[0] = 5'(v.id_s0);  id_src[1] = 5'(v.id_s1);    id_src_used = 2'(v.used);
  endtask

  function automatic bit slotBusy(input int s);
    foreach (ops[k]) if (ops[k].slot == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int freeSlot();
    for (int s = 0; s < MC_DEPTH; s++) if (!slotBusy(s)) return s;
    return -1;
  endfunction

  function automatic bit destBusy(input logic [4:0] d);
    if (d == 5'd0) return 1'b0;
    foreach (ops[k]) if (ops[k].dest == d) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] expFwd(input logic [4:0] s);
    if (s == 5'd0) return 2'(FWD_RF);
    if (mem_regwrite && mem_dest == s) return mem_alt ? 2'(FWD_MEM_ALT) : 2'(FWD_MEM);
    if (wb_regwrite && wb_dest == s) return 2'(FWD_WB);
    return 2'(FWD_RF);
  endfunction

  function automatic bit expStall();
    int retiring = 0;
    bit lu = 1'b0, raw = 1'b0, waw = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      if (ex_is_load && ex_regwrite && ex_dest != 0 && id_src_used[i] && id_src[i] == ex_dest) lu = 1'b1;
    foreach (ops[k]) begin
      if (ops[k].ret == cyc) retiring++;
      if (ops[k].dest != 0) begin
        for (int i = 0; i < NUM_SRC; i++)
          if (id_src_used[i] && id_src[i] == ops[k].dest) raw = 1'b1;
        if (id_regwrite && id_dest == ops[k].dest) waw = 1'b1;
      end
    end
    return lu || raw || waw ||
           (id_mc && (ops.size() - retiring + int'(ex_mc_issue)) == MC_DEPTH);
  endfunction

  task automatic runRandom(input int n_cycles);
    bit          st;
    int          fs;
    logic [3:0]  exp_wb;
    op_t         keep[$];
    ops.delete();
    m_cnt = '0;
    cyc = 0;
    for (int n = 0; n < n_cycles; n++) begin
      RST          = ($urandom_range(0, 59) == 0);
      perf_clr     = ($urandom_range(0, 29) == 0);
      for (int i = 0; i < NUM_SRC; i++) begin
        ex_src[i] = 5'($urandom_range(0, 7));
        id_src[i] = 5'($urandom_range(0, 7));
      end
      id_src_used  = 2'($urandom_range(0, 3));
      id_dest      = 5'($urandom_range(0, 7));
      id_regwrite  = 1'($urandom_range(0, 1));
      id_mc        = ($urandom_range(0, 2) == 0);
      ex_dest      = 5'($urandom_range(0, 7));
      ex_regwrite  = 1'($urandom_range(0, 1));
      ex_is_load   = ($urandom_range(0, 3) == 0);
      mem_dest     = 5'($urandom_range(0, 7));
      mem_regwrite = 1'($urandom_range(0, 1));
      mem_alt      = 1'($urandom_range(0, 1));
      wb_dest      = 5'($urandom_range(0, 7));
      wb_regwrite  = 1'($urandom_range(0, 1));
      ex_mc_lat    = 4'($urandom_range(0, 8));
      fs           = freeSlot();
      ex_mc_issue  = ($urandom_range(0, 1) == 0) && (fs >= 0) && !destBusy(ex_dest);
      #3;
      st = expStall();
      checkOutput("rnd_fwd0", 32'(fwd_sel[0]), 32'(expFwd(ex_src[0])));
      checkOutput("rnd_fwd1", 32'(fwd_sel[1]), 32'(expFwd(ex_src[1])));
      checkOutput("rnd_stall", 32'(stall), 32'(st));
      checkOutput("rnd_tag", 32'(mc_tag), (fs < 0) ? 32'd0 : 32'(fs));
      exp_wb = '0;
      foreach (ops[k]) if (ops[k].ret == cyc) begin
        exp_wb[ops[k].slot] = 1'b1;
        checkOutput("rnd_wb_dest", 32'(mc_wb_dest[ops[k].slot]), 32'(ops[k].dest));
      end
      checkOutput("rnd_wb_valid", 32'(mc_wb_valid), 32'(exp_wb));
      checkOutput("rnd_stall_count", stall_count, m_cnt);
      if (RST) begin
        ops.delete();
        m_cnt = '0;
      end else begin
        if (perf_clr) m_cnt = '0;
        else if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        if (ex_mc_issue)
          ops.push_back('{slot: fs, dest: ex_dest,
                          ret: cyc + ((ex_mc_lat == 0) ? 1 : int'(ex_mc_lat))});
        keep.delete();
        foreach (ops[k]) if (ops[k].ret > cyc) keep.push_back(ops[k]);
        ops = keep;
      end
      nextCycle();
      cyc++;
    end
    RST = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t tbl[11];
    tbl[0]  = '{3, 4, 3, 1, 0, 4, 1, 0, 0, 0, 0, 0, 0, 1, 2, 0};
    tbl[1]  = '{3, 4, 3, 1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    tbl[2]  = '{3, 4, 3, 1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 3, 2, 0};
    tbl[3]  = '{0, 4, 0, 1, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0};
    tbl[4]  = '{3, 4, 3, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 5, 1, 1, 5, 0, 1, 0, 0, 1};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 5, 1, 1, 5, 0, 0, 0, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 5, 0, 1, 5, 0, 1, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 5, 1, 1, 6, 5, 2, 0, 0, 1};
    tbl[10] = '{5, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};

    clearInputs();
    RST = 1'b1;
    nextCycle();
    doReset();
    #3;
    checkOutput("reset_fwd0", 32'(fwd_sel[0]), 32'(FWD_RF));
    checkOutput("reset_fwd1", 32'(fwd_sel[1]), 32'(FWD_RF));
    checkOutput("reset_stall", 32'(stall), 32'd0);
    checkOutput("reset_tag", 32'(mc_tag), 32'd0);
    checkOutput("reset_wb_valid", 32'(mc_wb_valid), 32'd0);
    checkOutput("reset_stall_count", stall_count, 32'd0);
    nextCycle();

    foreach (tbl[k]) begin
      applyStimulus(tbl[k]);
      #3;
      checkOutput($sformatf("vec%0d_fwd0", k), 32'(fwd_sel[0]), 32'(tbl[k].f0));
      checkOutput($sformatf("vec%0d_fwd1", k), 32'(fwd_sel[1]), 32'(tbl[k].f1));
      checkOutput($sformatf("vec%0d_stall", k), 32'(stall), 32'(tbl[k].st));
      nextCycle();
    end

    // MC op latency 3 with a dependent source waiting in IF/ID.
    doReset();
    ex_mc_issue = 1'b1; ex_dest = 5'd7; ex_mc_lat = 4'd3;
    #3;
    checkOutput("l3_tag", 32'(mc_tag), 32'd0);
    nextCycle();
    ex_mc_issue = 1'b0; ex_dest = 5'd0;
    id_src[1] = 5'd7; id_src_used = 2'b10;
    for (int c = 1; c <= 3; c++) begin
      #3;
      checkOutput($sformatf("l3_stall_c%0d", c), 32'(stall), 32'd1);
      checkOutput($sformatf("l3_wb_valid_c%0d", c), 32'(mc_wb_valid), (c == 3) ? 32'h1 : 32'h0);
      if (c == 3) checkOutput("l3_wb_dest", 32'(mc_wb_dest[0]), 32'd7);
      nextCycle();
    end
    #3;
    checkOutput("l3_release", 32'(stall), 32'd0);
    checkOutput("l3_freed", 32'(mc_wb_valid), 32'd0);

    // Latency 0 behaves as latency 1.
    doReset();
    ex_mc_issue = 1'b1; ex_dest = 5'd6; ex_mc_lat = 4'd0;
    nextCycle();
    ex_mc_issue = 1'b0;
    #3;
    checkOutput("l0_wb_valid_c1", 32'(mc_wb_valid), 32'h1);
    checkOutput("l0_wb_dest", 32'(mc_wb_dest[0]), 32'd6);
    nextCycle();
    #3;
    checkOutput("l0_wb_valid_c2", 32'(mc_wb_valid), 32'h0);

    // Fill every slot, then a multi-cycle op in IF/ID waits for a slot.
    doReset();
    for (int k = 0; k < 4; k++) begin
      ex_mc_issue = 1'b1; ex_dest = 5'(10 + k); ex_mc_lat = 4'd8;
      #3;
      checkOutput($sformatf("fill_tag%0d", k), 32'(mc_tag), 32'(k));
      nextCycle();
    end
    ex_mc_issue = 1'b0; ex_dest = 5'd0; id_mc = 1'b1;
    for (int c = 4; c <= 7; c++) begin
      #3;
      checkOutput($sformatf("struct_stall_c%0d", c), 32'(stall), 32'd1);
      nextCycle();
    end
    #3;
    checkOutput("struct_release", 32'(stall), 32'd0);
    checkOutput("struct_retire0", 32'(mc_wb_valid), 32'h1);
    nextCycle();
    ex_mc_issue = 1'b1; ex_dest = 5'd14; ex_mc_lat = 4'd2;
    #3;
    checkOutput("reuse_tag", 32'(mc_tag), 32'd0);
    nextCycle();
    clearInputs();

    // WAW on an in-flight op, then reset while it is still pending.
    doReset();
    ex_mc_issue = 1'b1; ex_dest = 5'd9; ex_mc_lat = 4'd5;
    nextCycle();
    ex_mc_issue = 1'b0; ex_dest = 5'd0;
    id_regwrite = 1'b1; id_dest = 5'd9;
    #3;
    checkOutput("waw_stall", 32'(stall), 32'd1);
    nextCycle();
    #3;
    checkOutput("waw_stall_count", stall_count, 32'd1);
    RST = 1'b1;
    nextCycle();
    RST = 1'b0;
    #3;
    checkOutput("midrst_stall", 32'(stall), 32'd0);
    checkOutput("midrst_count", stall_count, 32'd0);
    checkOutput("midrst_wb_valid", 32'(mc_wb_valid), 32'd0);
    checkOutput("midrst_tag", 32'(mc_tag), 32'd0);
    nextCycle();
    nextCycle();
    #3;
    checkOutput("midrst_no_retire", 32'(mc_wb_valid), 32'd0);
    clearInputs();

    // Counter saturation and clear-over-increment.
    doReset();
    ex_is_load = 1'b1; ex_regwrite = 1'b1; ex_dest = 5'd5;
    id_src[0] = 5'd5; id_src_used = 2'b01;
    dut.perf_cnt = 32'hFFFF_FFFD;
    nextCycle();
    #3;
    checkOutput("sat_step", stall_count, 32'hFFFF_FFFE);
    nextCycle();
    nextCycle();
    nextCycle();
    #3;
    checkOutput("sat_hold", stall_count, 32'hFFFF_FFFF);
    perf_clr = 1'b1;
    nextCycle();
    perf_clr = 1'b0;
    #3;
    checkOutput("clr_wins", stall_count, 32'd0);
    nextCycle();

    doReset();
    runRandom(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
